multi_tick_gen: RTL

- Parametrised, synthesizable multi-channel generator of divided clocks and strobes.
- Each channel produces a square wave with a programmable half-period and start phase, a per-rising-edge strobe, a rising-edge counter and an odd/even parity flag.
- Channel 0's count is compared against a programmable terminal count; reaching it freezes all channels and raises done.
- Serves as the synthesizable stimulus/timebase block for scheduler and delay test benches.

---
 rtl/multi_tick_gen_pkg.sv | 22 ++
 rtl/tick_chan.sv | 89 ++++++++
 rtl/multi_tick_gen.sv | 79 +++++++
 3 files changed

// File: rtl/multi_tick_gen_pkg.sv
// Shared types and helpers for the multi-channel divided-clock / strobe generator.
package multi_tick_gen_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_DELAY,
    CH_RUN,
    CH_HALT
  } ch_state_t;

  typedef enum logic [1:0] {
    G_IDLE,
    G_RUN,
    G_DONE
  } g_state_t;

  // A programmed half-period of 0 behaves exactly like 1.
  function automatic logic [63:0] clamp_half(input logic [63:0] hp);
    return (hp == 64'd0) ? 64'd1 : hp;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One generator channel: phase delay, half-period down-counter, square wave,
// rising-edge strobe and rising-edge counter.
module tick_chan
  import multi_tick_gen_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CYC_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             halt,
  input  logic             clr,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] phase,
  output logic             gen_clk,
  output logic             rise,
  output logic [CYC_W-1:0] cyc,
  output logic             will_rise
);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_r;
  logic [CNT_W-1:0] h_eff;

  assign h_eff     = CNT_W'(clamp_half(64'(half_period)));
  assign will_rise = (state == CH_RUN) && (cnt == '0) && !gen_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CH_IDLE;
      cnt     <= '0;
      h_r     <= '0;
      gen_clk <= 1'b0;
      rise    <= 1'b0;
      cyc     <= '0;
    end else if (clr) begin
      state   <= CH_IDLE;
      cnt     <= '0;
      h_r     <= '0;
      gen_clk <= 1'b0;
      rise    <= 1'b0;
      cyc     <= '0;
    end else if (go) begin
      h_r     <= h_eff;
      gen_clk <= 1'b0;
      rise    <= 1'b0;
      cyc     <= '0;
      if (phase == '0) begin
        state <= CH_RUN;
        cnt   <= h_eff - 1'b1;
      end else begin
        state <= CH_DELAY;
        cnt   <= phase - 1'b1;
      end
    end else begin
      rise <= 1'b0;
      // The terminal edge still performs its normal update; HALT only freezes later edges.
      case (state)
        CH_DELAY: begin
          if (cnt == '0) begin
            state <= CH_RUN;
            cnt   <= h_r - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
          if (halt) state <= CH_HALT;
        end
        CH_RUN: begin
          if (cnt == '0) begin
            cnt     <= h_r - 1'b1;
            gen_clk <= ~gen_clk;
            if (!gen_clk) begin
              rise <= 1'b1;
              if (!(SAT && (cyc == '1))) cyc <= cyc + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
          if (halt) state <= CH_HALT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel divided-clock and strobe generator with a global run FSM that
// stops every channel once channel 0 reaches its terminal rising-edge count.
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int CYC_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic [NUM_CH*CNT_W-1:0] half_period,
  input  logic [NUM_CH*CNT_W-1:0] phase,
  input  logic [CYC_W-1:0]        max_cyc,
  output logic [NUM_CH-1:0]       gen_clk,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH*CYC_W-1:0] cyc,
  output logic [NUM_CH-1:0]       parity,
  output logic                    busy,
  output logic                    done
);

  g_state_t         g_state;
  logic [CYC_W-1:0] max_r;
  logic [NUM_CH-1:0] will_rise;
  logic             accept;
  logic             term;

  assign accept = start && !clear && (g_state != G_RUN);
  // An all-ones terminal count is unreachable since channel 0 saturates there.
  assign term   = (g_state == G_RUN) && will_rise[0] &&
                  (cyc[CYC_W-1:0] == max_r) && (max_r != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_state <= G_IDLE;
      max_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      g_state <= G_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (accept) begin
      g_state <= G_RUN;
      max_r   <= max_cyc;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (term) begin
      g_state <= G_DONE;
      busy    <= 1'b0;
      done    <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(
      .CNT_W(CNT_W),
      .CYC_W(CYC_W),
      .SAT  (g == 0)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .go         (accept),
      .halt       (term),
      .clr        (clear),
      .half_period(half_period[g*CNT_W +: CNT_W]),
      .phase      (phase[g*CNT_W +: CNT_W]),
      .gen_clk    (gen_clk[g]),
      .rise       (rise[g]),
      .cyc        (cyc[g*CYC_W +: CYC_W]),
      .will_rise  (will_rise[g])
    );
    assign parity[g] = cyc[g*CYC_W];
  end

endmodule
